// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core EX-stage helpers.
// Covers the shift unit's op codes, FSM states and word width.
package mips_pkg;

  localparam int WORD = 32;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle for seq_shift_unit.
// Handshake: start is sampled only while the unit is idle or in its done cycle.
// A sampled start captures Data_in/Shamt/Op. busy is high while shifting.
// done pulses for one cycle, and Data_out is valid from that cycle until the
// next completion.
interface seq_shift_unit_if;
  import mips_pkg::*;

  logic            start;
  logic [WORD-1:0] Data_in;
  logic [4:0]      Shamt;
  logic [1:0]      Op;
  logic [WORD-1:0] Data_out;
  logic            busy;
  logic            done;

  modport master (output start, Data_in, Shamt, Op,
                  input  Data_out, busy, done);
  modport slave  (input  start, Data_in, Shamt, Op,
                  output Data_out, busy, done);
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves work by k positions (0..4).
// SRA refills from bit 31, which still holds the sign captured at start.
module shift_step
  import mips_pkg::*;
(
  input  logic [WORD-1:0] work,
  input  logic [2:0]      k,
  input  logic [1:0]      op,
  output logic [WORD-1:0] nxt
);

  // Select the shift flavour; k==0 passes work through unchanged.
  always_comb begin
    nxt = work;
    case (op)
      OP_SLL:  nxt = work << k;
      OP_SRL:  nxt = work >> k;
      OP_SRA:  nxt = $signed(work) >>> k;
      OP_ROTR: nxt = (k == 3'd0) ? work
                                 : ((work >> k) | (work << (6'd32 - {3'b000, k})));
      default: nxt = work;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit shifting STEP bits per cycle.
// The pipeline stalls on busy. Data_out is written only on completion.
module seq_shift_unit
  import mips_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_shift_unit_if.slave    bus,
  output state_t             dbg_state
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
    $error("seq_shift_unit: STEP must be 1, 2 or 4");
  end

  state_t          state, state_nxt;
  logic [WORD-1:0] work;
  logic [4:0]      cnt;
  logic [1:0]      op;
  logic [WORD-1:0] data_out;
  logic [WORD-1:0] step_out;
  logic [2:0]      k;
  logic            accept;
  logic            last;

  // Take the full STEP unless fewer positions remain, so cnt never underflows.
  assign k      = (cnt < 5'(STEP)) ? cnt[2:0] : 3'(STEP);
  assign last   = (cnt == {2'b00, k});
  assign accept = bus.start && (state == S_IDLE || state == S_DONE);

  shift_step u_step (
    .work (work),
    .k    (k),
    .op   (op),
    .nxt  (step_out)
  );

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (bus.Shamt == 5'd0) ? S_DONE : S_SHIFT;
        else        state_nxt = S_IDLE;
      end
      S_SHIFT: if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture on accept, step while shifting, publish on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      cnt      <= '0;
      op       <= OP_SLL;
      data_out <= '0;
    end else if (accept) begin
      work <= bus.Data_in;
      cnt  <= bus.Shamt;
      op   <= bus.Op;
      if (bus.Shamt == 5'd0) data_out <= bus.Data_in;
    end else if (state == S_SHIFT) begin
      work <= step_out;
      cnt  <= cnt - {2'b00, k};
      if (last) data_out <= step_out;
    end
  end

  assign bus.Data_out = data_out;
  assign bus.busy     = (state == S_SHIFT);
  assign bus.done     = (state == S_DONE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit with STEP=1 and STEP=4 instances.
module tb_seq_shift_unit;
  import mips_pkg::*;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_shift_unit_if b1 ();
  seq_shift_unit_if b4 ();
  state_t st1, st4;

  seq_shift_unit #(.STEP(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(st1));
  seq_shift_unit #(.STEP(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4), .dbg_state(st4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver.
  task automatic drive(input int sel, input logic s, input logic [31:0] d,
                       input logic [4:0] sh, input logic [1:0] o);
    if (sel == 1) begin
      b1.start = s; b1.Data_in = d; b1.Shamt = sh; b1.Op = o;
    end else begin
      b4.start = s; b4.Data_in = d; b4.Shamt = sh; b4.Op = o;
    end
  endtask

  function automatic logic [31:0] rd_dout(input int sel);
    return (sel == 1) ? b1.Data_out : b4.Data_out;
  endfunction
  function automatic logic rd_busy(input int sel);
    return (sel == 1) ? b1.busy : b4.busy;
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel == 1) ? b1.done : b4.done;
  endfunction
  function automatic state_t rd_state(input int sel);
    return (sel == 1) ? st1 : st4;
  endfunction

  // One full operation: checks latency, busy length, result, hold and pulse width.
  task automatic run_op(input int sel, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] o, input logic [31:0] exp,
                        input int exp_edges, input bit noise, input string tag);
    logic [31:0] prev;
    int edges, busy_cnt;
    bit seen;
    @(negedge clk);
    prev = rd_dout(sel);
    drive(sel, 1'b1, d, sh, o);
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (rd_done(sel)) begin
        seen = 1'b1;
        chk({tag, "_no_overlap"}, 32'(rd_busy(sel)), 32'd0);
        drive(sel, 1'b0, d, sh, o);
      end else begin
        if (rd_busy(sel)) begin
          busy_cnt++;
          chk({tag, "_hold"}, rd_dout(sel), prev);
        end
        if (noise)
          drive(sel, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)));
        else
          drive(sel, 1'b0, d, sh, o);
      end
    end
    chk({tag, "_seen_done"}, 32'(seen), 32'd1);
    chk({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges - 1));
    chk({tag, "_data"}, rd_dout(sel), exp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(rd_done(sel)), 32'd0);
    chk({tag, "_idle"}, 32'(rd_state(sel)), 32'(S_IDLE));
    chk({tag, "_data_held"}, rd_dout(sel), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, '0, '0, OP_SLL);
    drive(4, 1'b0, '0, '0, OP_SLL);
    #1;
    chk("rst_dout1", b1.Data_out, 32'd0);
    chk("rst_busy1", 32'(b1.busy), 32'd0);
    chk("rst_done1", 32'(b1.done), 32'd0);
    chk("rst_state4", 32'(st4), 32'(S_IDLE));
    chk("rst_dout4", b4.Data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of an SRA by 20.
    @(negedge clk);
    drive(1, 1'b1, 32'h8000_0000, 5'd20, OP_SRA);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 32'h8000_0000, 5'd20, OP_SRA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before_rst", 32'(b1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", b1.Data_out, 32'd0);
    chk("mid_rst_busy", 32'(b1.busy), 32'd0);
    chk("mid_rst_done", 32'(b1.done), 32'd0);
    chk("mid_rst_state", 32'(st1), 32'(S_IDLE));
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(b1.done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(b1.done), 32'd0);
      chk("post_rst_idle", 32'(st1), 32'(S_IDLE));
    end

    // STEP=1 directed vectors.
    run_op(1, 32'h0000_0005, 5'd2, OP_SLL,  32'h0000_0014, 3, 1'b0, "sll5x2");
    run_op(1, 32'hF000_0000, 5'd4, OP_SRA,  32'hFF00_0000, 5, 1'b0, "sra_f0");
    run_op(1, 32'hF000_0000, 5'd4, OP_SRL,  32'h0F00_0000, 5, 1'b0, "srl_f0");
    run_op(1, 32'h0000_0001, 5'd1, OP_ROTR, 32'h8000_0000, 2, 1'b0, "rotr1");
    run_op(1, 32'hDEAD_BEEF, 5'd0, OP_SRL,  32'hDEAD_BEEF, 1, 1'b0, "zero_amt");
    run_op(1, 32'h1234_5678, 5'd8, OP_ROTR, 32'h7812_3456, 9, 1'b0, "rotr8");

    // STEP=4 directed vectors, including partial last steps and input noise.
    run_op(4, 32'hFFFF_FFFF, 5'd31, OP_SRL, 32'h0000_0001, 9, 1'b1, "s4_srl31");
    run_op(4, 32'h0000_0003, 5'd31, OP_SLL, 32'h8000_0000, 9, 1'b0, "s4_sll31");
    run_op(4, 32'h8000_0000, 5'd7,  OP_SRA, 32'hFF00_0000, 3, 1'b0, "s4_sra7");
    run_op(4, 32'h0000_00F1, 5'd5,  OP_ROTR, 32'h8800_0007, 3, 1'b1, "s4_rotr5");
    run_op(4, 32'hF000_0000, 5'd4,  OP_SRA, 32'hFF00_0000, 2, 1'b0, "s4_sra4");

    // Back-to-back: new start accepted in the DONE cycle.
    @(negedge clk);
    drive(1, 1'b1, 32'd1, 5'd1, OP_SLL);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 32'd1, 5'd1, OP_SLL);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_first_done", 32'(b1.done), 32'd1);
    chk("b2b_first_data", b1.Data_out, 32'd2);
    drive(1, 1'b1, 32'd3, 5'd1, OP_SLL);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_no_gap_state", 32'(st1), 32'(S_SHIFT));
    chk("b2b_no_gap_busy", 32'(b1.busy), 32'd1);
    chk("b2b_done_fell", 32'(b1.done), 32'd0);
    drive(1, 1'b0, 32'd0, 5'd0, OP_SLL);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_done", 32'(b1.done), 32'd1);
    chk("b2b_second_data", b1.Data_out, 32'd6);
    @(negedge clk);
    chk("b2b_back_idle", 32'(st1), 32'(S_IDLE));

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle shift unit for the EX stage of the pipelined MIPS core. It executes SLL/SRL/SRA/ROTR on a 32-bit operand, STEP bit positions per cycle, using a start/busy/done handshake. It complements the fixed combinational left-by-2 Shifter_32 on the branch path: it adds right, arithmetic and rotate shifts with a variable amount. The hazard unit stalls the pipeline while busy is high.

Parameters:
STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4; any other value is a synthesis error.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
Data_in  in  32  operand, captured when start is accepted
Shamt  in  5  shift amount 0..31, captured with Data_in
Op  in  2  operation select, captured with Data_in
Data_out  out  32  last completed result; held until the next completion
busy  out  1  high while in SHIFT
done  out  1  one-cycle pulse in DONE; Data_out is valid from this cycle onward

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; Data_out=0; busy=0; done=0.
  - Internal working register and count cleared.
  - Reset mid-SHIFT aborts the operation; no done pulse is produced.
- Op encoding:
  - 00 SLL: zero fill.
  - 01 SRL: zero fill.
  - 11 SRA: fill with the sign bit captured at start.
  - 10 ROTR: bits shifted out of bit 0 re-enter at bit 31.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads work=Data_in, cnt=Shamt and op.
  - Next state is DONE if Shamt==0, otherwise SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge shifts work by k=min(STEP,cnt) and sets cnt=cnt-k.
  - When cnt reaches 0 on an edge, Data_out<=work shifted by k, and next state is DONE.
  - start is ignored; the inputs may change freely.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation; done then falls).
  - Otherwise next state is IDLE.
- Shamt==0 path: Data_out<=Data_in at the accept edge.
- Latency: done is high in the cycle after edge number ceil(Shamt/STEP)+1, counting the accept edge as edge 1.
  - Examples: Shamt=0 → 1 edge; Shamt=31, STEP=1 → 32 edges; Shamt=31, STEP=4 → 9 edges.
- busy equals (state==SHIFT); it never overlaps done.
- Data_out changes only on a completion edge or on reset, never during SHIFT.
- No arithmetic overflow exists; all widths are fixed at 32; cnt is 5 bits and never underflows, because k≤cnt.

Decomposition:
- Shared package mips_pkg:
  - Op constants OP_SLL=2'b00, OP_SRL=2'b01, OP_ROTR=2'b10, OP_SRA=2'b11.
  - State encoding constants S_IDLE, S_SHIFT, S_DONE.
  - Constant WORD=32.
- One natural sub-module, shift_step: combinational single-step shifter (work, k, op → next work) with k in 0..STEP.
  - Instantiated once.
  - Verified standalone against a reference model for all ops and k values.

Test Plan:
1. Reset mid-operation: start with Data_in=32'h8000_0000, Op=SRA, Shamt=20; assert rst_n=0 after 3 cycles → Data_out=0, busy=0, no done pulse; after release the unit idles and accepts a new start.
2. SLL, STEP=1: Data_in=5, Shamt=2, Op=SLL → busy high for 2 cycles, done on the 3rd, Data_out=32'h0000_0014.
3. SRA sign fill: Data_in=32'hF000_0000, Shamt=4, Op=SRA → Data_out=32'hFF00_0000; with Op=SRL → Data_out=32'h0F00_0000.
4. ROTR and zero amount:
   - Data_in=32'h0000_0001, Shamt=1, Op=ROTR → Data_out=32'h8000_0000.
   - Shamt=0, Data_in=32'hDEAD_BEEF → done after 1 edge, busy never high, Data_out=32'hDEAD_BEEF.
5. Max amount and input isolation, STEP=4: Data_in=32'hFFFF_FFFF, Shamt=31, Op=SRL → done after 9 edges, Data_out=1; start pulses and input changes during SHIFT are ignored.
6. Back-to-back: start asserted during DONE with Data_in=3, Shamt=1, Op=SLL → the second operation is accepted with no IDLE gap and Data_out=6 after its done pulse.
